// File: rtl/complex_addsub_pipe.sv
// Two-stage elastic complex adder/subtractor: A+B, A-B, A+jB, A-jB with
// optional round-half-up halving, saturate or wrap, overflow flag and tag.
module complex_addsub_pipe #(
    parameter int W    = 16,
    parameter int SAT  = 1,
    parameter int TAGW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*W-1:0]    in_a,
    input  logic [2*W-1:0]    in_b,
    input  logic [1:0]        in_op,
    input  logic              in_scale,
    input  logic [TAGW-1:0]   in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-1:0]    out_y,
    output logic              out_ovf,
    output logic [TAGW-1:0]   out_tag
);

    logic [W:0]      a_re, a_im, b_re, b_im;
    logic [W:0]      sum_re, sum_im;
    logic            s1_valid;
    logic [W:0]      s1_re, s1_im;
    logic            s1_scale;
    logic [TAGW-1:0] s1_tag;
    logic            s1_adv, s2_adv;
    logic [W-1:0]    r_re, r_im;
    logic            ovf_re, ovf_im;

    // Sign-extend operand components to W+1 bits
    assign a_re = {in_a[2*W-1], in_a[2*W-1:W]};
    assign a_im = {in_a[W-1],   in_a[W-1:0]};
    assign b_re = {in_b[2*W-1], in_b[2*W-1:W]};
    assign b_im = {in_b[W-1],   in_b[W-1:0]};

    // Elastic control: a stage advances when it is empty or its consumer advances
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Operation select; multiplying B by +/-j swaps and negates its components
    always_comb begin
        sum_re = '0;
        sum_im = '0;
        case (in_op)
            2'b00: begin sum_re = a_re + b_re; sum_im = a_im + b_im; end
            2'b01: begin sum_re = a_re - b_re; sum_im = a_im - b_im; end
            2'b10: begin sum_re = a_re - b_im; sum_im = a_im + b_re; end
            default: begin sum_re = a_re + b_im; sum_im = a_im - b_re; end
        endcase
    end

    // Reduce a W+1-bit sum to W bits; MSB of the return value is the overflow flag
    function automatic logic [W:0] reduce_comp(input logic [W:0] s, input logic scale);
        logic [W:0] t;
        logic [W:0] res;
        t   = s + (W+1)'(1);
        res = '0;
        if (scale)
            res = {1'b0, t[W:1]};
        else if (s[W] == s[W-1])
            res = {1'b0, s[W-1:0]};
        else if (SAT != 0)
            res = {1'b1, s[W], {(W-1){~s[W]}}};
        else
            res = {1'b1, s[W-1:0]};
        return res;
    endfunction

    // Stage-2 result reduction from the registered sums
    always_comb begin
        {ovf_re, r_re} = reduce_comp(s1_re, s1_scale);
        {ovf_im, r_im} = reduce_comp(s1_im, s1_scale);
    end

    // Stage 1 register: raw W+1-bit sums, scale and tag
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_scale <= 1'b0;
            s1_tag   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            s1_re    <= sum_re;
            s1_im    <= sum_im;
            s1_scale <= in_scale;
            s1_tag   <= in_tag;
        end
    end

    // Stage 2 register: final result, overflow and tag, held under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_ovf   <= 1'b0;
            out_tag   <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            out_y     <= {r_re, r_im};
            out_ovf   <= ovf_re | ovf_im;
            out_tag   <= s1_tag;
        end
    end

endmodule

// File: tb/tb_complex_addsub_pipe.sv
// Self-checking bench for complex_addsub_pipe: a saturating and a wrapping
// instance share stimulus; results are checked against an integer model.
module tb_complex_addsub_pipe;

    localparam int W    = 16;
    localparam int TAGW = 8;

    typedef struct {
        logic [2*W-1:0]  y_sat;
        logic [2*W-1:0]  y_wrap;
        logic            ovf;
        logic [TAGW-1:0] tag;
    } exp_t;

    typedef struct {
        logic [2*W-1:0]  a;
        logic [2*W-1:0]  b;
        logic [1:0]      op;
        logic            sc;
        logic [TAGW-1:0] tag;
        exp_t            e;
    } txn_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, out_ready;
    logic [2*W-1:0]  in_a, in_b;
    logic [1:0]      in_op;
    logic            in_scale;
    logic [TAGW-1:0] in_tag;
    logic            in_ready, out_valid, out_ovf;
    logic [2*W-1:0]  out_y;
    logic [TAGW-1:0] out_tag;
    logic            in_ready_w, out_valid_w, out_ovf_w;
    logic [2*W-1:0]  out_y_w;
    logic [TAGW-1:0] out_tag_w;

    int unsigned tests = 0;
    int unsigned fails = 0;
    txn_t        stim[$];
    exp_t        sb[$];
    bit          rand_mode = 0;
    bit          prev_stall = 0;
    logic [2*W-1:0]  held_y, held_y_w;
    logic            held_ovf;
    logic [TAGW-1:0] held_tag;

    always #5 clk = ~clk;

    complex_addsub_pipe #(.W(W), .SAT(1), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_scale(in_scale), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_ovf(out_ovf), .out_tag(out_tag)
    );

    complex_addsub_pipe #(.W(W), .SAT(0), .TAGW(TAGW)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_scale(in_scale), .in_tag(in_tag),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_y(out_y_w),
        .out_ovf(out_ovf_w), .out_tag(out_tag_w)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One component: plain integer arithmetic, floor division for the halving
    task automatic model_comp(input int s, input logic sc,
                              output logic [W-1:0] rs, output logic [W-1:0] rw, output logic o);
        int lo, hi, t, r;
        logic [31:0] v;
        lo = -(1 << (W-1));
        hi = (1 << (W-1)) - 1;
        o  = 1'b0;
        if (sc) begin
            t = s + 1;
            r = (t >= 0) ? t / 2 : -((1 - t) / 2);
            v = 32'(r);
            rs = v[W-1:0];
            rw = v[W-1:0];
        end else begin
            v  = 32'(s);
            rw = v[W-1:0];
            rs = v[W-1:0];
            if (s > hi) begin o = 1'b1; v = 32'(hi); rs = v[W-1:0]; end
            if (s < lo) begin o = 1'b1; v = 32'(lo); rs = v[W-1:0]; end
        end
    endtask

    function automatic int sx(input logic [W-1:0] x);
        return int'($signed(x));
    endfunction

    task automatic model(inout txn_t t);
        int ar, ai, br, bi, sre, sim;
        logic [W-1:0] rs_re, rw_re, rs_im, rw_im;
        logic o_re, o_im;
        ar = sx(t.a[2*W-1:W]); ai = sx(t.a[W-1:0]);
        br = sx(t.b[2*W-1:W]); bi = sx(t.b[W-1:0]);
        case (t.op)
            2'd0: begin sre = ar + br; sim = ai + bi; end
            2'd1: begin sre = ar - br; sim = ai - bi; end
            2'd2: begin sre = ar - bi; sim = ai + br; end
            default: begin sre = ar + bi; sim = ai - br; end
        endcase
        model_comp(sre, t.sc, rs_re, rw_re, o_re);
        model_comp(sim, t.sc, rs_im, rw_im, o_im);
        t.e.y_sat  = {rs_re, rs_im};
        t.e.y_wrap = {rw_re, rw_im};
        t.e.ovf    = o_re | o_im;
        t.e.tag    = t.tag;
    endtask

    task automatic push_dir(input logic [2*W-1:0] a, input logic [2*W-1:0] b, input logic [1:0] op,
                            input logic sc, input logic [TAGW-1:0] tag,
                            input logic [2*W-1:0] ys, input logic [2*W-1:0] yw, input logic ovf);
        txn_t t;
        t.a = a; t.b = b; t.op = op; t.sc = sc; t.tag = tag;
        t.e.y_sat = ys; t.e.y_wrap = yw; t.e.ovf = ovf; t.e.tag = tag;
        stim.push_back(t);
    endtask

    function automatic logic [W-1:0] rnd_comp();
        case ($urandom_range(3))
            0: return {1'b0, {(W-1){1'b1}}};
            1: return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    task automatic push_rand(input int unsigned n);
        txn_t t;
        for (int unsigned i = 0; i < n; i++) begin
            t.a   = {rnd_comp(), rnd_comp()};
            t.b   = {rnd_comp(), rnd_comp()};
            t.op  = 2'($urandom);
            t.sc  = 1'($urandom);
            t.tag = TAGW'($urandom);
            model(t);
            stim.push_back(t);
        end
    endtask

    // One clock: drive inputs, check at the falling edge, advance past the rising edge
    task automatic tick();
        logic in_fire, out_fire;
        if (rand_mode) out_ready = ($urandom_range(99) < 70);
        if (stim.size() != 0 && (!rand_mode || $urandom_range(99) < 75)) begin
            in_valid = 1'b1;
            in_a = stim[0].a; in_b = stim[0].b; in_op = stim[0].op;
            in_scale = stim[0].sc; in_tag = stim[0].tag;
        end else begin
            in_valid = 1'b0;
            in_a = $urandom; in_b = $urandom; in_op = 2'($urandom);
            in_scale = 1'($urandom); in_tag = TAGW'($urandom);
        end
        @(negedge clk);
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        if (rst) begin
            prev_stall = 0;
        end else begin
            check("in_ready", 64'(in_ready), 64'((sb.size() < 2) || out_ready));
            check("in_ready_wrap", 64'(in_ready_w), 64'((sb.size() < 2) || out_ready));
            check("out_valid_wrap", 64'(out_valid_w), 64'(out_valid));
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_y", 64'(out_y), 64'(held_y));
                check("hold_y_wrap", 64'(out_y_w), 64'(held_y_w));
                check("hold_ovf", 64'(out_ovf), 64'(held_ovf));
                check("hold_tag", 64'(out_tag), 64'(held_tag));
            end
            prev_stall = out_valid && !out_ready;
            held_y = out_y; held_y_w = out_y_w; held_ovf = out_ovf; held_tag = out_tag;
            if (out_fire) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 64'(1), 64'(0));
                end else begin
                    check("y_sat", 64'(out_y), 64'(sb[0].y_sat));
                    check("y_wrap", 64'(out_y_w), 64'(sb[0].y_wrap));
                    check("ovf", 64'(out_ovf), 64'(sb[0].ovf));
                    check("ovf_wrap", 64'(out_ovf_w), 64'(sb[0].ovf));
                    check("tag", 64'(out_tag), 64'(sb[0].tag));
                    check("tag_wrap", 64'(out_tag_w), 64'(sb[0].tag));
                    void'(sb.pop_front());
                end
            end
            if (in_fire) begin
                sb.push_back(stim[0].e);
                void'(stim.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int unsigned limit);
        int unsigned n;
        n = 0;
        while ((stim.size() != 0 || sb.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        check("drain_done", 64'(stim.size() + sb.size()), 64'(0));
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, 64'(out_valid), 64'(0));
        check({name, "_y"}, 64'(out_y), 64'(0));
        check({name, "_y_wrap"}, 64'(out_y_w), 64'(0));
        check({name, "_ovf"}, 64'(out_ovf), 64'(0));
        check({name, "_tag"}, 64'(out_tag), 64'(0));
        check({name, "_in_ready"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = '0; in_scale = 1'b0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;

        // Positive overflow on re, with latency check
        out_ready = 1'b1;
        push_dir(32'h7FFF_0001, 32'h0001_0002, 2'd0, 1'b0, 8'h5A, 32'h7FFF_0003, 32'h8000_0003, 1'b1);
        tick();
        check("lat_cycle1", 64'(out_valid), 64'(0));
        tick();
        check("lat_cycle2", 64'(out_valid), 64'(1));
        drain(20);

        // Scaling boundaries, negative overflows, then back-to-back op sweep
        push_dir(32'h7FFF_0001, 32'h0001_0002, 2'd0, 1'b1, 8'h5B, 32'h4000_0002, 32'h4000_0002, 1'b0);
        push_dir(32'h8000_8000, 32'h8000_8000, 2'd0, 1'b1, 8'h5C, 32'h8000_8000, 32'h8000_8000, 1'b0);
        push_dir(32'h8000_0000, 32'h0001_0000, 2'd1, 1'b0, 8'h5D, 32'h8000_0000, 32'h7FFF_0000, 1'b1);
        push_dir(32'h0000_8000, 32'h0001_0000, 2'd3, 1'b0, 8'h5E, 32'h0000_8000, 32'h0000_7FFF, 1'b1);
        push_dir(32'h0064_00C8, 32'h000A_0014, 2'd2, 1'b0, 8'h01, 32'h0050_00D2, 32'h0050_00D2, 1'b0);
        push_dir(32'h0064_00C8, 32'h000A_0014, 2'd3, 1'b0, 8'h02, 32'h0078_00BE, 32'h0078_00BE, 1'b0);
        push_dir(32'h0064_00C8, 32'h000A_0014, 2'd1, 1'b0, 8'h03, 32'h005A_00B4, 32'h005A_00B4, 1'b0);
        drain(40);

        // Backpressure: six offered with output stalled, only two fit
        out_ready = 1'b0;
        push_rand(6);
        repeat (6) tick();
        check("stall_accepted", 64'(sb.size()), 64'(2));
        check("stall_pending", 64'(stim.size()), 64'(4));
        out_ready = 1'b1;
        drain(40);

        // Reset with two transactions in flight
        push_rand(2);
        tick();
        tick();
        check("pre_reset_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        sb.delete();
        rst = 1'b0;
        check_idle("midreset");
        out_ready = 1'b1;
        push_dir(32'h0064_00C8, 32'h000A_0014, 2'd1, 1'b0, 8'hC3, 32'h005A_00B4, 32'h005A_00B4, 1'b0);
        tick();
        check("post_reset_lat1", 64'(out_valid), 64'(0));
        tick();
        check("post_reset_lat2", 64'(out_valid), 64'(1));
        drain(20);

        // Random traffic with random valid/ready
        rand_mode = 1;
        push_rand(10000);
        drain(60000);
        rand_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
